// File: rtl/fft_lsram_pkg.sv
// fft_lsram_pkg: shared constants, read-controller state type and address bit-reversal
// for the FFT result LSRAM stream reader.
package fft_lsram_pkg;
   localparam int FFT_ADDR_W = 11;
   localparam int FFT_DATA_W = 64;
   localparam int FFT_RD_LAT = 2;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;

   function automatic logic [FFT_ADDR_W-1:0] bitrev(input logic [FFT_ADDR_W-1:0] a);
      logic [FFT_ADDR_W-1:0] r;
      for (int i = 0; i < FFT_ADDR_W; i++) r[i] = a[FFT_ADDR_W-1-i];
      return r;
   endfunction
endpackage

// File: rtl/fft_rd_skid_fifo.sv
// fft_rd_skid_fifo: register FIFO with fall-through read; an empty FIFO forwards a
// same-cycle push straight to the output, and the occupancy feeds the read credit check.
module fft_rd_skid_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH+1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [CW-1:0]    o_count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_rd, r_wr;
   logic [CW-1:0]    r_count;
   logic             w_empty, w_we, w_re;

   // a push that bypasses an empty FIFO and is popped at once is never stored
   assign w_empty = (r_count == '0);
   assign w_we    = i_push & ~(w_empty & i_pop);
   assign w_re    = i_pop & ~w_empty;
   assign o_valid = ~w_empty | i_push;
   assign o_data  = ~w_empty ? r_mem[r_rd] : (i_push ? i_data : '0);
   assign o_count = r_count;

   always_ff @(posedge i_clk)
      if (w_we) r_mem[r_wr] <= i_data;

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (w_we) r_wr <= (r_wr == PW'(DEPTH-1)) ? '0 : r_wr + 1'b1;
         if (w_re) r_rd <= (r_rd == PW'(DEPTH-1)) ? '0 : r_rd + 1'b1;
         r_count <= r_count + CW'(w_we) - CW'(w_re);
      end
endmodule

// File: rtl/fft_lsram_stream_reader.sv
// fft_lsram_stream_reader: sweeps the LSRAM read port over one frame and streams the words
// with credit-limited issue into a skid FIFO. FFT_RD_BITREV_EN selects bit-reversed addressing.
module fft_lsram_stream_reader
   import fft_lsram_pkg::*;
#(
   parameter int ADDR_W = FFT_ADDR_W,
   parameter int DATA_W = FFT_DATA_W,
   parameter int RD_LAT = FFT_RD_LAT
) (
   input  logic              i_rclock,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [ADDR_W:0]   i_frame_len,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_raddr,
   output logic              o_do_en,
   output logic              o_do_rst,
   input  logic [DATA_W-1:0] i_do,
   output logic [DATA_W-1:0] o_m_data,
   output logic              o_m_valid,
   input  logic              i_m_ready,
   output logic              o_m_last
);
   localparam int DEPTH = RD_LAT + 2;
   localparam int CW    = $clog2(DEPTH+1);
   localparam int SW    = CW + 1;

   rd_state_t         r_state, w_next;
   logic [ADDR_W:0]   r_len, r_issue, r_push_idx, w_len_in;
   logic [RD_LAT-1:0] r_vld;
   logic [CW-1:0]     w_count;
   logic [SW-1:0]     w_used;
   logic [DATA_W:0]   w_fifo_out;
   logic              w_accept, w_issue, w_push, w_pop, w_last_in, w_drain_done;

`ifdef FFT_RD_BITREV_EN
   assign w_len_in = {1'b1, {ADDR_W{1'b0}}};
   assign o_raddr  = bitrev(r_issue[ADDR_W-1:0]);
`else
   assign w_len_in = (i_frame_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : i_frame_len;
   assign o_raddr  = r_issue[ADDR_W-1:0];
`endif

   // credits: reads in flight plus words parked in the FIFO never exceed DEPTH
   assign w_used       = SW'($countones(r_vld)) + SW'(w_count);
   assign w_accept     = (r_state == IDLE) & i_start;
   assign w_issue      = (r_state == RUN) & (r_issue < r_len) & (w_used < SW'(DEPTH));
   assign w_push       = r_vld[RD_LAT-1];
   assign w_pop        = o_m_valid & i_m_ready;
   assign w_last_in    = (r_push_idx == r_len - 1'b1);
   assign w_drain_done = (r_vld == '0) & (w_count == '0);

   always_comb begin
      w_next = r_state;
      if (w_accept) w_next = RUN;
      if ((r_state == RUN) && w_issue && (r_issue == r_len - 1'b1)) w_next = DRAIN;
      if ((r_state == DRAIN) && w_drain_done) w_next = IDLE;
   end

   always_ff @(posedge i_rclock or posedge i_rst)
      if (i_rst) begin
         r_state    <= IDLE;
         r_len      <= '0;
         r_issue    <= '0;
         r_push_idx <= '0;
         r_vld      <= '0;
      end else begin
         r_state <= w_next;
         r_vld   <= (r_vld << 1) | RD_LAT'(w_issue);
         if (w_accept) begin
            r_len      <= w_len_in;
            r_issue    <= '0;
            r_push_idx <= '0;
         end else begin
            if (w_issue) r_issue <= r_issue + 1'b1;
            if (w_push) r_push_idx <= r_push_idx + 1'b1;
         end
      end

   fft_rd_skid_fifo #(.WIDTH(DATA_W+1), .DEPTH(DEPTH), .CW(CW)) u_fifo (
      .i_clk   (i_rclock),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_data  ({w_last_in, i_do}),
      .i_pop   (w_pop),
      .o_valid (o_m_valid),
      .o_data  (w_fifo_out),
      .o_count (w_count)
   );

   assign {o_m_last, o_m_data} = w_fifo_out;
   assign o_busy   = (r_state != IDLE);
   assign o_done   = (r_state == DRAIN) & w_drain_done;
   assign o_do_en  = ~i_rst;
   assign o_do_rst = (r_state == IDLE);
endmodule

// File: doc/fft_lsram_stream_reader.md
# fft_lsram_stream_reader

Read-side controller for the FFT result LSRAM (2048 x 64, two-port, registered read port). On a START request it sweeps the memory's read port over one frame, absorbs the fixed RAM read latency, and presents the words on a valid/ready stream with a last-word marker. Backpressure is handled with credit-limited address issue into a small skid FIFO, so no word is ever dropped or duplicated. It sits between the LSRAM read port (RADDR/DO/DO_en/DO_rst) and the downstream result consumer.

## Interface
- ADDR_W, 11: RAM address width; frame holds up to 2^ADDR_W words.
- DATA_W, 64: RAM and stream data width.
- RD_LAT, 2: cycles from RADDR presented to DO valid (address register plus output register).
- RCLOCK  in  1  sole clock; also drives the RAM read port.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle frame request; sampled only in IDLE.
- FRAME_LEN  in  ADDR_W+1  words per frame, 1..2^ADDR_W; value 0 means 2^ADDR_W; sampled with START.
- BUSY  out  1  high from the cycle after START acceptance through the DONE cycle.
- DONE  out  1  one-cycle pulse after the last word handshakes.
- RADDR  out  ADDR_W  RAM read address.
- DO_en  out  1  RAM output-register enable.
- DO_rst  out  1  RAM output-register synchronous clear, active-high.
- DO  in  DATA_W  RAM read data.
- M_DATA  out  DATA_W  stream data.
- M_VALID  out  1  stream valid.
- M_READY  in  1  stream ready.
- M_LAST  out  1  marks the final word of the frame; qualified by M_VALID.

## Operation
- Reset values: RADDR=0, BUSY=0, DONE=0, M_VALID=0, M_LAST=0, M_DATA=0, DO_en=0, DO_rst=1. Reset discards the FIFO, in-flight reads and counters, including mid-frame.
- State machine:
  - IDLE: START=1 latches FRAME_LEN (0 maps to 2^ADDR_W), clears the counters and moves to RUN.
  - RUN: issues addresses. Moves to DRAIN in the cycle the last address is issued.
  - DRAIN: waits until in-flight=0 and the FIFO is empty, then pulses DONE and returns to IDLE.
- START is ignored outside IDLE.
- Issue rule: one address per cycle while issue count < length and (in-flight + FIFO occupancy) < DEPTH, where DEPTH = RD_LAT+2. RADDR advances only on issue and holds otherwise.
- An RD_LAT-deep valid shift register tags each issued address. A tagged DO is written into the FIFO in the cycle it emerges.
- FIFO is first-word-fall-through.
  - M_VALID = FIFO not empty.
  - Pop on M_VALID & M_READY.
  - A push and a pop in the same cycle leave occupancy unchanged.
- M_LAST=1 on the word whose output index equals length-1.
- DO_en=1 whenever not in reset. DO_rst=1 in IDLE and 0 in RUN/DRAIN.
- Counters are ADDR_W+1 bits, so a full 2^ADDR_W frame does not wrap before the terminal compare.
- M_VALID is never deasserted without a handshake. M_DATA and M_LAST are stable while M_VALID=1 and M_READY=0.

## Timing
- START accepted at cycle 0. BUSY=1 and first RADDR presented at cycle 1. First DO at cycle 1+RD_LAT, and M_VALID=1 in that same cycle (fall-through).
- With M_READY held high: one word per cycle. The last word handshakes at cycle RD_LAT+length, DONE pulses at cycle RD_LAT+length+1, and BUSY drops at the following cycle.
- With M_READY low: issue stops when credits are exhausted. The FIFO holds at most DEPTH words, and no overflow is possible.
- A new START is accepted no earlier than the cycle after DONE.

## Configuration
- FFT_RD_BITREV_EN defined: RADDR is the ADDR_W-bit bit-reversal of the issue counter, giving FFT output in natural frequency order. FRAME_LEN is ignored and the length is fixed to 2^ADDR_W.
- Not defined: RADDR equals the issue counter (sequential), and FRAME_LEN is honoured.

## Structure
- Package fft_lsram_pkg holds:
  - constants FFT_ADDR_W=11, FFT_DATA_W=64, FFT_RD_LAT=2;
  - the state enum (IDLE, RUN, DRAIN);
  - a bitrev function.
- Sub-module fft_rd_skid_fifo: register FIFO with DEPTH=RD_LAT+2, width DATA_W+1 (data plus last flag), fall-through read, and an occupancy count output used for credits.

## Test plan
- Sequential mode, FRAME_LEN=8, RAM[i]=i, M_READY=1 -> M_DATA 0..7 on consecutive cycles from cycle 3; M_LAST with 7; DONE at cycle 11.
- FRAME_LEN=0, M_READY=1 -> 2048 words 0..2047; M_LAST on word 2047; RADDR never wraps before the end.
- FRAME_LEN=16, M_READY toggled 1-0-0-1 repeatedly -> all 16 words in order with no drops or duplicates; in-flight + occupancy never exceeds 4; RADDR holds while out of credit.
- FFT_RD_BITREV_EN defined, RAM[i]=i -> first outputs 0, 1024, 512, 1536, 256; M_LAST on 2047.
- RST asserted mid-frame (after word 5 of 16) -> all outputs return to reset values the same cycle; next START with FRAME_LEN=4 yields 0..3 cleanly.
- START pulsed during RUN -> ignored; exactly one DONE per accepted frame.
